mips_mc_controller: RTL and testbench
=====================================

# mips_mc_controller

Multicycle control FSM for the MIPS core: sequences the shared memory, instruction register, register file, ALU and PC over 3–5 cycles per instruction. It replaces single-cycle decode when the datapath runs in multicycle mode and sits between the instruction register opcode field and all datapath enables and selects. It supports R-type, lw, sw, beq, addi and j, with a memory-ready handshake on every memory-access state.

## Interface
Parameters:
- none (state encoding fixed below)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  6  instr[31:26] from instruction register
- Zero  in  1  ALU zero flag, combinational from current ALU result
- mem_ready  in  1  memory completes current access this cycle
- IorD  out  1  memory address select (0 = PC, 1 = ALUOut)
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select (1 = rd, 0 = rt)
- MemtoReg  out  1  writeback select (1 = Data reg, 0 = ALUOut)
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A reg
- ALUSrcB  out  2  00 = B reg, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct decode
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- PCEn  out  1  PC load enable
- illegal_op  out  1  unsupported opcode seen in DECODE
- state  out  4  current state, for debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, BNE 12 (macro only). Codes 13–15 go to FETCH next cycle with all enables 0.
- Moore outputs; unlisted outputs are 0:
  - FETCH: ALUSrcB=01; IRWrite=PCEn=mem_ready.
  - DECODE: ALUSrcB=11.
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
  - MEMREAD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1.
  - MEMWRITE: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - ADDIWB: RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCSrc=01, PCEn=Zero.
  - JUMP: PCSrc=10, PCEn=1.
- Transitions:
  - FETCH→DECODE on mem_ready, else hold.
  - DECODE dispatches on Opcode: 000000→EXECUTE; 100011/101011→MEMADR; 000100→BRANCH; 001000→ADDIEX; 000010→JUMP; other→FETCH with illegal_op=1 for that DECODE cycle.
  - MEMADR→MEMREAD (lw) or MEMWRITE (sw), using the held Opcode.
  - MEMREAD→MEMWB on mem_ready, else hold.
  - MEMWRITE→FETCH on mem_ready, else hold; MemWrite stays high while holding.
  - EXECUTE→ALUWB; ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP→FETCH.
- Opcode must be stable from DECODE to end of instruction; it is guaranteed by IRWrite=0 outside FETCH.

## Timing
- Reset: async entry to FETCH. While rst_n=0: IRWrite, PCEn, MemWrite, RegWrite and illegal_op are forced 0; other outputs show FETCH values; state=0.
- Reset release mid-instruction restarts at FETCH; no partial writes complete.
- With mem_ready=1 constantly: beq/j take 3 cycles, R-type/sw/addi take 4, lw takes 5. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- PCEn in BRANCH/BNE is combinational from Zero in the same cycle.

## Configuration
- MIPS_BNE_EN defined: DECODE maps opcode 000101→BNE. BNE outputs match BRANCH except PCEn=~Zero; then BNE→FETCH.
- MIPS_BNE_EN undefined: 000101 is illegal (illegal_op=1, return to FETCH); state 12 is unreachable.

## Test plan
- Reset asserted mid-MEMWB (lw) -> state=0 immediately, RegWrite=0; after release, FETCH with mem_ready=1 gives IRWrite=PCEn=1.
- R-type (000000), mem_ready=1 -> states 0,1,6,7,0; ALUOp=10 in EXECUTE; RegDst=RegWrite=1 in ALUWB.
- lw (100011), mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; MemtoReg=RegWrite=1 only in state 4.
- beq (000100), Zero=1, then repeated with Zero=0 -> PCEn=1 and PCSrc=01 in BRANCH, then PCEn=0; both return to FETCH after 3 cycles.
- j (000010), then opcode 111111 -> JUMP has PCSrc=10 and PCEn=1; illegal opcode gives illegal_op=1 in DECODE, then FETCH with no writes.
- Opcode 000101 with Zero=0 -> with MIPS_BNE_EN defined: state 12 and PCEn=1; undefined: illegal_op=1.

Source files
------------

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle control FSM for the MIPS core.
// Sequences shared memory, IR, register file, ALU and PC over 3-5 cycles per
// instruction (R-type, lw, sw, beq, addi, j), with a mem_ready handshake in
// every memory-access state.
//
// Optional feature macro: MIPS_BNE_EN -- when defined, opcode 000101 (bne) is
// decoded to the BNE state; otherwise it is treated as an illegal opcode.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   Opcode[5:0]          instr[31:26] from the instruction register
//   Zero                 ALU zero flag (combinational)
//   mem_ready            memory completes the current access this cycle
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], PCEn   datapath controls (Moore,
//                        except FETCH/BRANCH/BNE enables follow mem_ready/Zero)
//   illegal_op           unsupported opcode seen in DECODE
//   state[3:0]           current state, for debug
module mips_mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ST_W  = 4;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef MIPS_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_4     = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;
    localparam logic [SEL_W-1:0] ALUOP_ADD  = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB  = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNC = 2'b10;
    localparam logic [SEL_W-1:0] PCSRC_RES  = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_OUT  = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JMP  = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_BNE      = 4'd12
    } state_e;

    state_e state_q;
    state_e state_d;
    logic   illegal_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode classification used by DECODE dispatch
    always_comb begin
        illegal_c = 1'b0;
        case (Opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_c = 1'b0;
`ifdef MIPS_BNE_EN
            OP_BNE:                                        illegal_c = 1'b0;
`endif
            default:                                       illegal_c = 1'b1;
        endcase
    end

    // Next-state logic; unused codes (and BNE when disabled) fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_BNE_EN
                    OP_BNE:       state_d = S_BNE;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode; write enables are masked while reset is held
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        ALUOp      = ALUOP_ADD;
        PCSrc      = PCSRC_RES;
        PCEn       = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = SRCB_4;
                IRWrite = mem_ready;
                PCEn    = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMMSH;
                illegal_op = illegal_c;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNC;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB:   RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_OUT;
                PCEn    = Zero;
            end
`ifdef MIPS_BNE_EN
            S_BNE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_SUB;
                PCSrc   = PCSRC_OUT;
                PCEn    = ~Zero;
            end
`endif
            S_JUMP: begin
                PCSrc = PCSRC_JMP;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            IRWrite    = 1'b0;
            PCEn       = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state = ST_W'(state_q);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: expected state/control words are
// pushed to a scoreboard queue as each cycle is driven and popped at negedge.
module tb_mips_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       mem_ready;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, illegal_op;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
    } obs_t;

    obs_t  sb_q[$];
    int    checks   = 0;
    int    failures = 0;
    string tag      = "init";

    mips_mc_controller dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .illegal_op(illegal_op),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    // Reference control word for a given state from the controller table
    function automatic obs_t model(input logic [3:0] s);
        obs_t e;
        logic legal;
        e = '0;
        e.st = s;
        legal = (Opcode == 6'b000000) || (Opcode == 6'b100011) ||
                (Opcode == 6'b101011) || (Opcode == 6'b000100) ||
                (Opcode == 6'b001000) || (Opcode == 6'b000010);
`ifdef MIPS_BNE_EN
        legal = legal || (Opcode == 6'b000101);
`endif
        case (s)
            4'd0:  begin e.alusrcb = 2'b01; e.irwrite = mem_ready; e.pcen = mem_ready; end
            4'd1:  begin e.alusrcb = 2'b11; e.illegal = ~legal; end
            4'd2, 4'd9: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
            4'd3:  e.iord = 1'b1;
            4'd4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
            4'd5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
            4'd6:  begin e.alusrca = 1'b1; e.aluop = 2'b10; end
            4'd7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
            4'd8:  begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = Zero; end
            4'd10: e.regwrite = 1'b1;
            4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
            4'd12: begin e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = ~Zero; end
            default: ;
        endcase
        if (!rst_n) begin
            e.irwrite = 1'b0; e.pcen = 1'b0; e.memwrite = 1'b0;
            e.regwrite = 1'b0; e.illegal = 1'b0;
        end
        return e;
    endfunction

    // Push the expectation, sample the DUT now, pop and compare
    task automatic check(input logic [3:0] s);
        obs_t e;
        obs_t o;
        sb_q.push_back(model(s));
        o = {state, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op};
        e = sb_q.pop_front();
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h (state obs=%0d exp=%0d)",
                   tag, o, e, o.st, e.st);
        end
    endtask

    // One clock cycle: inputs already driven; check at negedge, advance past posedge
    task automatic cyc(input logic [3:0] s);
        @(negedge clk);
        check(s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; Opcode = 6'b000000; Zero = 1'b0; mem_ready = 1'b1;
        #2;
        tag = "reset_hold";
        check(4'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        tag = "rtype";
        Opcode = 6'b000000;
        cyc(4'd0); cyc(4'd1); cyc(4'd6); cyc(4'd7);

        tag = "lw_stall";
        Opcode = 6'b100011;
        cyc(4'd0); cyc(4'd1); cyc(4'd2);
        mem_ready = 1'b0; cyc(4'd3); cyc(4'd3);
        mem_ready = 1'b1; cyc(4'd3); cyc(4'd4);

        tag = "sw_stall";
        Opcode = 6'b101011;
        cyc(4'd0); cyc(4'd1); cyc(4'd2);
        mem_ready = 1'b0; cyc(4'd5);
        mem_ready = 1'b1; cyc(4'd5);

        tag = "fetch_stall";
        Opcode = 6'b001000;
        mem_ready = 1'b0; cyc(4'd0); cyc(4'd0);
        mem_ready = 1'b1; cyc(4'd0);
        tag = "addi";
        cyc(4'd1); cyc(4'd9); cyc(4'd10);

        tag = "beq_taken";
        Opcode = 6'b000100; Zero = 1'b1;
        cyc(4'd0); cyc(4'd1); cyc(4'd8);
        tag = "beq_not_taken";
        Zero = 1'b0;
        cyc(4'd0); cyc(4'd1);
        @(negedge clk);
        check(4'd8);
        tag = "beq_zero_comb";
        Zero = 1'b1;
        #1 check(4'd8);
        @(posedge clk);
        #1 Zero = 1'b0;

        tag = "jump";
        Opcode = 6'b000010;
        cyc(4'd0); cyc(4'd1); cyc(4'd11);

        tag = "illegal";
        Opcode = 6'b111111;
        cyc(4'd0); cyc(4'd1);
        tag = "after_illegal";
        cyc(4'd0);

        tag = "bne";
        Opcode = 6'b000101; Zero = 1'b0;
        cyc(4'd1);
`ifdef MIPS_BNE_EN
        cyc(4'd12);
`endif
        cyc(4'd0);

        tag = "lw_to_memwb";
        Opcode = 6'b100011;
        cyc(4'd1); cyc(4'd2); cyc(4'd3);
        @(negedge clk);
        check(4'd4);
        tag = "async_reset";
        rst_n = 1'b0;
        #1 check(4'd0);
        @(posedge clk);
        #1 check(4'd0);
        rst_n = 1'b1;
        tag = "post_reset";
        cyc(4'd0); cyc(4'd1); cyc(4'd2);

        tag = "scoreboard_drain";
        checks++;
        assert (sb_q.size() === 0) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=0", tag, sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
